// File: rtl/reaction_arena.sv
// reaction_arena: multi-player reaction timer.
// Each round waits a pseudo-random delay (WAIT), then counts ticks (GO) until
// every eligible player has pressed or the counter saturates. It reports
// per-player ticks, false starts, the winner and the session-best time.
// Ports:
//   i_clk_50m        clock (single domain)
//   i_rst            synchronous active-high reset
//   i_btn_n          raw active-low asynchronous buttons, one per player
//   i_start          single-cycle request to arm a round
//   o_state          000 IDLE, 001 ARM, 010 WAIT, 011 GO, 100 DONE
//   o_ticks          per-player result, player p at [p*TICK_W +: TICK_W]; all-ones = none
//   o_done           player has a valid result this round
//   o_false_start    player pressed during WAIT
//   o_winner         index of the first recorder
//   o_winner_valid   o_winner is meaningful
//   o_best           lowest valid tick value since reset
//   o_round_pulse    one-cycle pulse on DONE entry
//   o_dbg_rnd        current LFSR value
module reaction_arena #(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned TICK_W      = 28,
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned DELAY_MIN   = 50000000,
  parameter int unsigned SPAN_W      = 10,
  parameter int unsigned DELAY_SHIFT = 16,
  localparam int unsigned WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          i_clk_50m,
  input  logic                          i_rst,
  input  logic [N_PLAYERS-1:0]          i_btn_n,
  input  logic                          i_start,
  output logic [2:0]                    o_state,
  output logic [N_PLAYERS*TICK_W-1:0]   o_ticks,
  output logic [N_PLAYERS-1:0]          o_done,
  output logic [N_PLAYERS-1:0]          o_false_start,
  output logic [WIN_W-1:0]              o_winner,
  output logic                          o_winner_valid,
  output logic [TICK_W-1:0]             o_best,
  output logic                          o_round_pulse,
  output logic [15:0]                   o_dbg_rnd
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [TICK_W-1:0] TICK_MAX = '1;
  localparam longint unsigned MAX_DELAY =
    64'(DELAY_MIN) + (((64'(1) << SPAN_W) - 64'(1)) << DELAY_SHIFT);

  // Configuration sanity checks at elaboration.
  if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
    $error("reaction_arena: N_PLAYERS must be 1..8");
  end
  if (SPAN_W < 1 || SPAN_W > 16) begin : g_bad_span
    $error("reaction_arena: SPAN_W must be 1..16");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("reaction_arena: DEB_CYCLES must be at least 1");
  end
  if (TICK_W < 64 && MAX_DELAY >= (64'(1) << TICK_W)) begin : g_delay_overflow
    $error("reaction_arena: maximum delay does not fit in TICK_W bits");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_ARM  = 3'b001,
    S_WAIT = 3'b010,
    S_GO   = 3'b011,
    S_DONE = 3'b100
  } state_e;

  // ---------------- input path: sync, debounce, press detect ----------------
  logic [N_PLAYERS-1:0] sync1_q, sync2_q, level_q, level_d, level_dly_q, press_q;
  logic [CNT_W-1:0]     cnt_q [N_PLAYERS];
  logic [CNT_W-1:0]     cnt_d [N_PLAYERS];

  // Level flips once the synced value has disagreed for DEB_CYCLES cycles.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) level_d[i] = sync2_q[i];
        else                                   cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      level_q     <= '1;
      level_dly_q <= '1;
      press_q     <= '0;
      cnt_q       <= '{default: '0};
    end else begin
      sync1_q     <= i_btn_n;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_dly_q & ~level_q;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------- round FSM and result registers ----------------
  state_e                      state_q, state_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [TICK_W-1:0]           delay_q, delay_d, tick_q, tick_d, best_q, best_d;
  logic [N_PLAYERS*TICK_W-1:0] ticks_q, ticks_d;
  logic [N_PLAYERS-1:0]        done_q, done_d, fs_q, fs_d, rec;
  logic [WIN_W-1:0]            winner_q, winner_d;
  logic                        win_valid_q, win_valid_d, pulse_q, pulse_d;
  logic                        enter_done, win_found, any_press;

  assign any_press = |press_q;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    delay_d     = delay_q;
    tick_d      = tick_q;
    ticks_d     = ticks_q;
    done_d      = done_q;
    fs_d        = fs_q;
    winner_d    = winner_q;
    win_valid_d = win_valid_q;
    best_d      = best_q;
    pulse_d     = 1'b0;
    rec         = '0;
    enter_done  = 1'b0;
    win_found   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start || any_press) state_d = S_ARM;
      end
      S_ARM: begin
        ticks_d     = '1;
        done_d      = '0;
        fs_d        = '0;
        win_valid_d = 1'b0;
        // Hold off until every debounced button is released.
        if (&level_q) begin
          delay_d = TICK_W'(DELAY_MIN) + (TICK_W'(lfsr_q[SPAN_W-1:0]) << DELAY_SHIFT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        fs_d = fs_q | press_q;
        if (delay_q != '0) delay_d = delay_q - TICK_W'(1);
        if (&fs_d) begin
          enter_done = 1'b1;
        end else if (delay_q <= TICK_W'(1)) begin
          state_d = S_GO;
          tick_d  = '0;
        end
      end
      S_GO: begin
        if (tick_q != TICK_MAX) tick_d = tick_q + TICK_W'(1);
        rec    = press_q & ~done_q & ~fs_q;
        done_d = done_q | rec;
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
          if (rec[p]) ticks_d[p*TICK_W +: TICK_W] = tick_q;
          // Lowest index wins among simultaneous first presses.
          if (rec[p] && !win_found && !win_valid_q) begin
            winner_d    = WIN_W'(p);
            win_valid_d = 1'b1;
            win_found   = 1'b1;
          end
        end
        // Finish once all eligible players were recorded on earlier edges, or on timeout.
        if ((&(done_q | fs_q)) || (tick_q == TICK_MAX)) enter_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_done) begin
      state_d = S_DONE;
      pulse_d = 1'b1;
      for (int unsigned p = 0; p < N_PLAYERS; p++) begin
        if (ticks_d[p*TICK_W +: TICK_W] < best_d) best_d = ticks_d[p*TICK_W +: TICK_W];
      end
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      delay_q     <= '0;
      tick_q      <= '0;
      ticks_q     <= '1;
      done_q      <= '0;
      fs_q        <= '0;
      winner_q    <= '0;
      win_valid_q <= 1'b0;
      best_q      <= '1;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      delay_q     <= delay_d;
      tick_q      <= tick_d;
      ticks_q     <= ticks_d;
      done_q      <= done_d;
      fs_q        <= fs_d;
      winner_q    <= winner_d;
      win_valid_q <= win_valid_d;
      best_q      <= best_d;
      pulse_q     <= pulse_d;
    end
  end

  assign o_state        = state_q;
  assign o_ticks        = ticks_q;
  assign o_done         = done_q;
  assign o_false_start  = fs_q;
  assign o_winner       = winner_q;
  assign o_winner_valid = win_valid_q;
  assign o_best         = best_q;
  assign o_round_pulse  = pulse_q;
  assign o_dbg_rnd      = lfsr_q;

endmodule

// File: tb/tb_reaction_arena.sv
// Testbench for reaction_arena: directed rounds plus randomized rounds, checked
// against a round-level model (press timing -> results) kept in the bench.
module tb_reaction_arena;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;  // edges from button drive edge to press pulse edge

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  btn_n;
  logic        start;
  logic [2:0]  o_state;
  logic [23:0] o_ticks;
  logic [1:0]  o_done, o_false_start;
  logic        o_winner, o_winner_valid, o_round_pulse;
  logic [11:0] o_best;
  logic [15:0] o_dbg_rnd;

  reaction_arena #(
    .N_PLAYERS(2), .TICK_W(12), .DEB_CYCLES(DEB),
    .DELAY_MIN(100), .SPAN_W(4), .DELAY_SHIFT(2)
  ) dut (
    .i_clk_50m(clk), .i_rst(rst), .i_btn_n(btn_n), .i_start(start),
    .o_state(o_state), .o_ticks(o_ticks), .o_done(o_done),
    .o_false_start(o_false_start), .o_winner(o_winner),
    .o_winner_valid(o_winner_valid), .o_best(o_best),
    .o_round_pulse(o_round_pulse), .o_dbg_rnd(o_dbg_rnd)
  );

  always #10 clk = ~clk;

  int          cyc = 0;
  int          npass = 0, nfail = 0, ntotal = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [11:0] m_best = 12'hFFF;
  int          press_at [2];
  int          release_at [2];
  int          glitch_at;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the LFSR model, then drive scheduled button events.
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    cyc++;
    m_lfsr = r ? 16'hACE1 : lfsr_next(m_lfsr);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (cyc == press_at[p])   btn_n[p] = 1'b0;
      if (cyc == release_at[p]) btn_n[p] = 1'b1;
    end
    if (cyc == glitch_at)     btn_n[0] = 1'b0;
    if (cyc == glitch_at + 3) btn_n[0] = 1'b1;
  endtask

  task automatic check_reset();
    check("rst_state", o_state, 0);
    check("rst_ticks", o_ticks, 24'hFFFFFF);
    check("rst_done", o_done, 0);
    check("rst_fs", o_false_start, 0);
    check("rst_winner", o_winner, 0);
    check("rst_wvalid", o_winner_valid, 0);
    check("rst_best", o_best, 12'hFFF);
    check("rst_pulse", o_round_pulse, 0);
    check("rst_lfsr", o_dbg_rnd, 16'hACE1);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_to_arm", o_state, 1);
  endtask

  // Step through ARM until WAIT; delay comes from the LFSR value in the exit cycle.
  task automatic arm_to_wait(output int w, output int d, input int exp_w);
    logic [15:0] prev_m;
    int lim;
    check("lfsr_model", o_dbg_rnd, m_lfsr);
    lim = cyc + 300;
    prev_m = m_lfsr;
    while (o_state !== 3'b010 && cyc < lim) begin
      prev_m = m_lfsr;
      step();
    end
    check("arm_to_wait", o_state, 2);
    if (exp_w >= 0) check("wait_entry_cycle", cyc, exp_w);
    w = cyc;
    d = 100 + 4 * prev_m[3:0];
  endtask

  // Play a round from ARM. off >= 0: pulse lands at GO count off; off < 0: pulse
  // lands -off cycles before GO (false start). h = player presses at all.
  task automatic play(input int off0, input bit h0, input int off1, input bit h1,
                      input bit glitch, input int exp_w);
    int off [2];
    bit h [2];
    logic [11:0] et [2];
    logic [1:0] efs, edn;
    logic ew, ewv;
    logic [11:0] eb;
    int w, d, g, lim, last, bestk, exp_done;
    bit allfs, alldone;
    off[0] = off0; off[1] = off1; h[0] = h0; h[1] = h1;
    arm_to_wait(w, d, exp_w);
    g = w + d;
    for (int p = 0; p < 2; p++) begin
      if (h[p]) begin
        press_at[p]   = g + off[p] - LAT;
        release_at[p] = press_at[p] + 10 + $urandom_range(6, 0);
      end
    end
    glitch_at = glitch ? g + 30 : -1;

    eb = m_best; ew = 1'b0; ewv = 1'b0; bestk = 1 << 30;
    allfs = 1'b1; alldone = 1'b1; last = -1;
    for (int p = 0; p < 2; p++) begin
      efs[p] = h[p] && off[p] < 0;
      edn[p] = h[p] && off[p] >= 0;
      et[p]  = edn[p] ? 12'(off[p]) : 12'hFFF;
      if (!efs[p]) allfs = 1'b0;
      if (!efs[p] && !edn[p]) alldone = 1'b0;
      if (edn[p] && off[p] < bestk) begin bestk = off[p]; ew = 1'(p); ewv = 1'b1; end
      if (edn[p] && et[p] < eb) eb = et[p];
      if (h[p] && g + off[p] > last) last = g + off[p];
    end
    exp_done = allfs ? last + 1 : (alldone ? last + 2 : g + 4096);

    lim = g + 4300;
    while (o_state !== 3'b100 && cyc < lim) begin
      step();
      if (!allfs && cyc == g - 1) check("wait_before_go", o_state, 2);
      if (!allfs && cyc == g)     check("go_after_delay", o_state, 3);
    end
    check("done_state", o_state, 4);
    check("done_cycle", cyc, exp_done);
    check("round_pulse", o_round_pulse, 1);
    check("ticks", o_ticks, {et[1], et[0]});
    check("done_mask", o_done, edn);
    check("false_start", o_false_start, efs);
    check("winner_valid", o_winner_valid, ewv);
    if (ewv) check("winner", o_winner, ew);
    check("best", o_best, eb);
    step();
    check("pulse_one_cycle", o_round_pulse, 0);
    check("done_hold", o_state, 4);
    check("ticks_hold", o_ticks, {et[1], et[0]});
    m_best = eb;
  endtask

  initial begin
    int w, d, e, lim, o0, o1;
    bit hh0, hh1;
    rst = 1'b1; btn_n = 2'b11; start = 1'b0;
    press_at = '{-1, -1}; release_at = '{-1, -1}; glitch_at = -1;
    repeat (3) step();
    check_reset();
    rst = 1'b0;
    step();
    check("lfsr_first_shift", o_dbg_rnd, m_lfsr);
    check("idle_after_reset", o_state, 0);

    // Reset, delay load and ordered presses.
    start_pulse();
    check("arm_ticks_reset", o_ticks, 24'hFFFFFF);
    check("arm_best_reset", o_best, 12'hFFF);
    check("arm_wvalid_reset", o_winner_valid, 0);
    play(37, 1, 52, 1, 0, cyc + 1);

    // Simultaneous presses.
    start_pulse();
    play(20, 1, 20, 1, 0, -1);

    // One false start, then a double false start.
    start_pulse();
    play(9, 1, -40, 1, 0, -1);
    start_pulse();
    play(-30, 1, -55, 1, 0, -1);

    // Glitch during GO and timeout with no presses.
    start_pulse();
    play(0, 0, 0, 0, 1, -1);

    // A press in DONE re-arms; ARM holds until the button is released.
    e = cyc;
    btn_n[1] = 1'b0;
    release_at[1] = e + 20;
    lim = e + 40;
    while (o_state !== 3'b001 && cyc < lim) step();
    check("press_to_arm_cycle", cyc, e + LAT + 1);
    play(60 + $urandom_range(40, 0), 1, 45, 1, 0, e + 20 + DEB + 3);

    // Mid-round reset during GO, then a normal round.
    start_pulse();
    arm_to_wait(w, d, -1);
    while (cyc < w + d + 20) step();
    check("go_before_reset", o_state, 3);
    rst = 1'b1;
    step();
    check_reset();
    rst = 1'b0;
    m_best = 12'hFFF;
    step();
    start_pulse();
    play(15, 1, 33, 1, 0, -1);

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      hh0 = ($urandom_range(3, 0) != 0);
      hh1 = ($urandom_range(3, 0) != 0);
      o0 = ($urandom_range(4, 0) == 0) ? -$urandom_range(80, 10) : $urandom_range(300, 0);
      o1 = ($urandom_range(4, 0) == 0) ? -$urandom_range(80, 10) : $urandom_range(300, 0);
      start_pulse();
      play(o0, hh0, o1, hh1, 0, -1);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
